// File: rtl/seq_detect_param_if.sv
// Serial detector bus: sample qualifier, data bit, clear, pattern/mask load,
// and the registered match pulse and counter returned by the detector.
interface seq_detect_param_if #(
  parameter int LEN   = 3,
  parameter int CNT_W = 8
);
  logic             en;
  logic             in;
  logic             clr;
  logic             cfg_we;
  logic [LEN-1:0]   cfg_pattern;
  logic [LEN-1:0]   cfg_mask;
  logic             out;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, in, clr, cfg_we, cfg_pattern, cfg_mask,
    input  out, match_cnt
  );

  modport slave (
    input  en, in, clr, cfg_we, cfg_pattern, cfg_mask,
    output out, match_cnt
  );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: masked compare of the last LEN
// qualified bits against a programmable pattern, with a saturating match count.
module seq_detect_param #(
  parameter int             LEN     = 3,
  parameter logic [LEN-1:0] PATTERN = 3'b110,
  parameter logic [LEN-1:0] MASK    = 3'b110,
  parameter bit             OVERLAP = 1'b0,
  parameter int             CNT_W   = 8
) (
  input logic               clk,
  input logic               reset,
  seq_detect_param_if.slave bus
);

  localparam int FILL_W = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(LEN);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  logic [LEN-1:0]    hist_p0;
  logic [FILL_W-1:0] fill_p0;
  logic [LEN-1:0]    pat_r;
  logic [LEN-1:0]    msk_r;
  logic              out_p1;
  logic [CNT_W-1:0]  cnt_p1;

  logic [LEN-1:0]    nh;
  logic [FILL_W-1:0] nf;
  logic              hit;

  // Stage p0 -> p1: candidate history and masked compare
  always_comb begin
    nh  = {hist_p0[LEN-2:0], bus.in};
    nf  = (fill_p0 == FULL) ? fill_p0 : fill_p0 + 1'b1;
    hit = (nf == FULL) && (((nh ^ pat_r) & msk_r) == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_p0 <= '0;
      fill_p0 <= '0;
      pat_r   <= PATTERN;
      msk_r   <= MASK;
      out_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else if (bus.clr) begin
      hist_p0 <= '0;
      fill_p0 <= '0;
      out_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else if (bus.cfg_we) begin
      // History bits are kept but must be refilled before the new pattern can match
      pat_r   <= bus.cfg_pattern;
      msk_r   <= bus.cfg_mask;
      fill_p0 <= '0;
      out_p1  <= 1'b0;
    end else if (bus.en) begin
      hist_p0 <= nh;
      out_p1  <= hit;
      if (hit) begin
        cnt_p1  <= sat_inc(cnt_p1);
        fill_p0 <= OVERLAP ? nf : '0;
      end else begin
        fill_p0 <= nf;
      end
    end else begin
      out_p1 <= 1'b0;
    end
  end

  assign bus.out       = out_p1;
  assign bus.match_cnt = cnt_p1;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: three instances (default, overlapping,
// 2-bit counter) share one stimulus stream; each test checks the relevant one.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, din, clr, cfg_we;
  logic [2:0] cfg_pattern, cfg_mask;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seq_detect_param_if #(.LEN(3), .CNT_W(8)) if_def ();
  seq_detect_param_if #(.LEN(3), .CNT_W(8)) if_ovl ();
  seq_detect_param_if #(.LEN(3), .CNT_W(2)) if_sat ();

  assign if_def.en = en;  assign if_def.in = din;  assign if_def.clr = clr;
  assign if_def.cfg_we = cfg_we;  assign if_def.cfg_pattern = cfg_pattern;
  assign if_def.cfg_mask = cfg_mask;
  assign if_ovl.en = en;  assign if_ovl.in = din;  assign if_ovl.clr = clr;
  assign if_ovl.cfg_we = cfg_we;  assign if_ovl.cfg_pattern = cfg_pattern;
  assign if_ovl.cfg_mask = cfg_mask;
  assign if_sat.en = en;  assign if_sat.in = din;  assign if_sat.clr = clr;
  assign if_sat.cfg_we = cfg_we;  assign if_sat.cfg_pattern = cfg_pattern;
  assign if_sat.cfg_mask = cfg_mask;

  seq_detect_param #(.LEN(3), .PATTERN(3'b110), .MASK(3'b110), .OVERLAP(1'b0), .CNT_W(8))
    u_def (.clk(clk), .reset(reset), .bus(if_def.slave));
  seq_detect_param #(.LEN(3), .PATTERN(3'b110), .MASK(3'b110), .OVERLAP(1'b1), .CNT_W(8))
    u_ovl (.clk(clk), .reset(reset), .bus(if_ovl.slave));
  seq_detect_param #(.LEN(3), .PATTERN(3'b110), .MASK(3'b110), .OVERLAP(1'b0), .CNT_W(2))
    u_sat (.clk(clk), .reset(reset), .bus(if_sat.slave));

  typedef struct {
    logic en;
    logic in;
    int   exp_out;
    int   exp_cnt;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic step(input logic e, input logic i, input logic c, input logic w);
    en = e; din = i; clr = c; cfg_we = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; din = 1'b0; clr = 1'b0; cfg_we = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    cfg_pattern = 3'b000;
    cfg_mask    = 3'b000;
    tbl[0] = '{1'b1, 1'b1, 0, 0};
    tbl[1] = '{1'b1, 1'b1, 0, 0};
    tbl[2] = '{1'b1, 1'b0, 1, 1};
    tbl[3] = '{1'b1, 1'b1, 0, 1};
    tbl[4] = '{1'b1, 1'b1, 0, 1};
    tbl[5] = '{1'b1, 1'b1, 1, 2};

    do_reset();
    chk("reset_out", int'(if_def.out), 0);
    chk("reset_cnt", int'(if_def.match_cnt), 0);

    // Non-overlapping 1,1,0,1,1,1
    for (int k = 0; k < 6; k++) begin
      step(tbl[k].en, tbl[k].in, 1'b0, 1'b0);
      chk($sformatf("t1_out[%0d]", k), int'(if_def.out), tbl[k].exp_out);
      chk($sformatf("t1_cnt[%0d]", k), int'(if_def.match_cnt), tbl[k].exp_cnt);
    end

    // 1,1,1,1 on overlapping and non-overlapping instances
    do_reset();
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("t2_ovl_out3", int'(if_ovl.out), 1);
    chk("t2_def_out3", int'(if_def.out), 1);
    step(1, 1, 0, 0);
    chk("t2_ovl_out4", int'(if_ovl.out), 1);
    chk("t2_ovl_cnt",  int'(if_ovl.match_cnt), 2);
    chk("t2_def_out4", int'(if_def.out), 0);
    chk("t2_def_cnt",  int'(if_def.match_cnt), 1);

    // Qualifier gap inside the sequence
    do_reset();
    step(1, 1, 0, 0);
    for (int g = 0; g < 3; g++) begin
      step(0, 0, 0, 0);
      chk($sformatf("t3_gap_out[%0d]", g), int'(if_def.out), 0);
    end
    step(1, 1, 0, 0);
    chk("t3_pre_out", int'(if_def.out), 0);
    step(1, 0, 0, 0);
    chk("t3_out", int'(if_def.out), 1);
    chk("t3_cnt", int'(if_def.match_cnt), 1);
    step(0, 0, 0, 0);
    chk("t3_pulse_end", int'(if_def.out), 0);

    // Clear mid-sequence
    do_reset();
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("t4_clr_out", int'(if_def.out), 0);
    step(1, 0, 0, 0);
    chk("t4_clr_nomatch", int'(if_def.out), 0);
    chk("t4_clr_cnt", int'(if_def.match_cnt), 0);

    // Asynchronous reset between edges
    do_reset();
    step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
    chk("t4_pre_out", int'(if_def.out), 1);
    #2 reset = 1'b0;
    #1;
    chk("t4_async_out", int'(if_def.out), 0);
    chk("t4_async_cnt", int'(if_def.match_cnt), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    step(1, 0, 0, 0);
    chk("t4_partial_discard", int'(if_def.out), 0);

    // Counter saturation with CNT_W=2
    do_reset();
    for (int m = 1; m <= 5; m++) begin
      step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 0, 0, 0);
      chk($sformatf("t5_out[%0d]", m), int'(if_sat.out), 1);
      chk($sformatf("t5_cnt[%0d]", m), int'(if_sat.match_cnt), (m > 3) ? 3 : m);
    end

    // Run-time reconfiguration to 101/111
    do_reset();
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    cfg_pattern = 3'b101; cfg_mask = 3'b111;
    step(1, 1, 0, 1);
    chk("t6_cfg_out", int'(if_def.out), 0);
    step(1, 1, 0, 0);
    chk("t6_s1", int'(if_def.out), 0);
    step(1, 0, 0, 0);
    chk("t6_s2", int'(if_def.out), 0);
    step(1, 1, 0, 0);
    chk("t6_match", int'(if_def.out), 1);
    step(1, 1, 0, 0); step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("t6_nomatch", int'(if_def.out), 0);
    chk("t6_cnt", int'(if_def.match_cnt), 1);

    // All-zero mask matches every sample once history is full
    do_reset();
    cfg_pattern = 3'b000; cfg_mask = 3'b000;
    step(0, 0, 0, 1);
    step(1, 1, 0, 0);
    chk("t7_s1", int'(if_ovl.out), 0);
    step(1, 0, 0, 0);
    chk("t7_s2", int'(if_ovl.out), 0);
    step(1, 1, 0, 0);
    chk("t7_s3", int'(if_ovl.out), 1);
    step(1, 0, 0, 0);
    chk("t7_s4", int'(if_ovl.out), 1);
    chk("t7_cnt", int'(if_ovl.match_cnt), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
